// File: rtl/counter_pkg.sv
// Shared definitions for the counter-sharing arbiter: FSM state encoding and
// a helper that yields the counter reload value.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Widest counter the helper below can serve; callers size-cast the result.
    localparam int MAX_WIDTH = 32;

    // Reload value for the counter when a new owner is granted.
    function automatic logic [MAX_WIDTH-1:0] zero_count();
        return '0;
    endfunction

endpackage

// File: rtl/counter_share_arbiter_rr_pick.sv
// Combinational round-robin selector: finds the first set request bit at or
// above ptr, wrapping past the top back to bit 0.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [2*N-1:0]   req_twice;
    logic [N-1:0]     rotated;
    logic [IDX_W-1:0] offset;
    logic [IDX_W:0]   sum;
    logic [IDX_W:0]   wrapped;

    assign req_twice = {req, req};

    // rotated[k] is the request that sits k positions above the pointer.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign rotated[gi] = req_twice[{1'b0, ptr} + (IDX_W+1)'(gi)];
        end
    endgenerate

    // Lowest set bit of the rotated vector is the distance to the winner.
    always_comb begin
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IDX_W'(i);
            end
        end
    end

    // Map the distance back to an absolute index modulo N.
    always_comb begin
        sum     = {1'b0, ptr} + {1'b0, offset};
        wrapped = (sum >= (IDX_W+1)'(N)) ? (sum - (IDX_W+1)'(N)) : sum;
        idx     = IDX_W'(wrapped);
    end

    assign valid = |req;

endmodule

// File: rtl/counter_share_arbiter.sv
// Shares one up-counting interval timer between NUM_REQ requesters. The timer
// is granted round-robin, counts 0..D, then pulses done to its owner.
module counter_share_arbiter
    import counter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 10,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] reqDelay,
    input  logic                     abort,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [IDX_W-1:0]         activeIdx,
    output logic [WIDTH-1:0]         countValue
);

    state_t               state_reg, state_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [IDX_W-1:0]     ptr_reg, ptr_next;
    logic [WIDTH-1:0]     cnt_reg, cnt_next;
    logic [WIDTH-1:0]     delay_reg, delay_next;

    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic [WIDTH-1:0]     delay_arr [NUM_REQ];

    // Unpack the flat delay bus into one entry per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_delay
            assign delay_arr[gi] = reqDelay[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Pointer advances one past the owner that just released the timer.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // Next-state logic: grant on request, count to the latched delay, release.
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        idx_next   = idx_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        delay_next = delay_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next           = ST_COUNT;
                    grant_next           = '0;
                    grant_next[pick_idx] = 1'b1;
                    idx_next             = pick_idx;
                    delay_next           = delay_arr[pick_idx];
                    cnt_next             = WIDTH'(zero_count());
                end
            end
            ST_COUNT: begin
                // Abort takes priority even on the terminal count.
                if (abort) begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                    ptr_next   = next_ptr(idx_reg);
                end else if (cnt_reg == delay_reg) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                grant_next = '0;
                ptr_next   = next_ptr(idx_reg);
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any count in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            idx_reg   <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= WIDTH'(zero_count());
            delay_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            idx_reg   <= idx_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            delay_reg <= delay_next;
        end
    end

    // Done mirrors the one-hot grant for the single DONE cycle.
    assign done       = (state_reg == ST_DONE) ? grant_reg : '0;
    assign busy       = (state_reg != ST_IDLE);
    assign grant      = grant_reg;
    assign activeIdx  = idx_reg;
    assign countValue = cnt_reg;

endmodule
